mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, RAM word-address width (RAM holds 2**ADDR_W 32-bit words).
REQ-002 Parameter BASE, default 32'h00000000, byte address mapped to RAM word 0.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 i_address  in  32  instruction-port byte address.
REQ-006 i_read  in  1  instruction-port read request.
REQ-007 i_waitrequest  out  1  high = instruction transfer not complete.
REQ-008 i_readdata  out  32  instruction read data, valid when i_read and !i_waitrequest.
REQ-009 d_address  in  32  data-port byte address.
REQ-010 d_read, d_write  in  1 each  data-port read and write requests.
REQ-011 d_byteenable  in  4  data-port write byte lanes.
REQ-012 d_writedata  in  32  data-port write data.
REQ-013 d_waitrequest  out  1  high = data transfer not complete.
REQ-014 d_readdata  out  32  data read data, valid when d_read and !d_waitrequest.
REQ-015 ram_address  out  ADDR_W  word address: (addr - BASE)[ADDR_W+1:2].
REQ-016 ram_read, ram_write  out  1 each  RAM strobes.
REQ-017 ram_byteenable  out  4  d_byteenable on writes; 4'hF on reads.
REQ-018 ram_writedata  out  32  d_writedata, passed through unchanged.
REQ-019 ram_readdata  in  32  RAM read data, registered by the RAM, valid one cycle after ram_read.
REQ-020 fault  out  1  sticky out-of-range access flag.

Function
REQ-021 FSM states: IDLE, RD_I, RD_D.
REQ-022 IDLE: grant one pending requester per cycle; pending = i_read for instruction port, d_read|d_write for data port.
REQ-023 Granted write: ram_write=1 in the same cycle; d_waitrequest=0 in that cycle; next state IDLE.
REQ-024 Granted read: ram_read=1 in the grant cycle; requester waitrequest=1; next state RD_I or RD_D.
REQ-025 RD_x: requester waitrequest=0; x_readdata=ram_readdata; next state IDLE; read latency is exactly 2 cycles; read throughput is one read per 2 cycles.
REQ-026 Non-completing cycles: waitrequest=1 and readdata=32'h0 on both ports.
REQ-027 d_read and d_write both high: treated as a write; the read is ignored.
REQ-028 Out-of-range address (addr < BASE or addr >= BASE + 4*2**ADDR_W): no RAM strobe is issued; the transfer still completes with normal timing and readdata 32'h0; fault is set to 1.
REQ-029 Requester drops its request while in RD_x (protocol violation): FSM still returns to IDLE; no data is delivered; no RAM strobe is issued.
REQ-030 Address bits [1:0] are ignored.

Reset
REQ-031 While reset=1: state=IDLE, ram_read=ram_write=0, both waitrequests=1, both readdata=0, fault=0, round-robin pointer=data port.
REQ-032 Reset asserted in RD_x aborts the read; the first cycle after reset is IDLE.

Configuration
REQ-033 Macro MEM_ARBITER_ROUND_ROBIN_EN.
- Defined: simultaneous requests in IDLE go to the port not granted last; the pointer updates on every grant.
- Undefined: the data port always wins; instruction port starvation is permitted.

Verification
REQ-034 Data write: d_write=1, d_address=32'h8, d_byteenable=4'b0011, d_writedata=32'hAABBCCDD -> same cycle ram_write=1, ram_address=2, ram_byteenable=4'b0011, d_waitrequest=0.
REQ-035 Instruction read: i_read=1, i_address=32'h4, RAM word1=32'h12345678 -> cycle0 ram_read=1 and i_waitrequest=1; cycle1 i_waitrequest=0 and i_readdata=32'h12345678.
REQ-036 Contention over 4 cycles, i_read and d_read held continuously, both reads issued at IDLE -> without macro, d granted at cycles 0 and 2 while i_waitrequest stays 1; with macro, grants alternate d (cycle 0), i (cycle 2).
REQ-037 Out of range: d_read with d_address=32'h4000 (ADDR_W=12) -> no ram_read; cycle1 d_waitrequest=0 and d_readdata=0; fault=1 until reset.
REQ-038 Reset in RD_D -> next cycle state IDLE, d_waitrequest=1, fault=0; a new d_read then completes with 2-cycle latency.

Source files
------------

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (instruction / data) arbiter in front of a single-port
//            32-bit RAM with registered read data. Reads take two cycles,
//            writes complete in the grant cycle, and out-of-range accesses
//            complete without touching the RAM while setting a sticky fault.
// Options  : MEM_ARBITER_ROUND_ROBIN_EN - round-robin arbitration between the
//            ports on simultaneous requests (default: data port always wins).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    // instruction port
    input  logic [31:0]       i_address,
    input  logic              i_read,
    output logic              i_waitrequest,
    output logic [31:0]       i_readdata,
    // data port
    input  logic [31:0]       d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [3:0]        d_byteenable,
    input  logic [31:0]       d_writedata,
    output logic              d_waitrequest,
    output logic [31:0]       d_readdata,
    // RAM side
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_writedata,
    input  logic [31:0]       ram_readdata,
    // status
    output logic              fault
);

    // Size of the mapped window in bytes; 33 bits so that a negative offset
    // (address below BASE) wraps above it and is caught by the same compare.
    localparam logic [32:0] c_SPAN = 33'd1 << (ADDR_W + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_I = 2'd1,
        RD_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_rd_oor;      // read in flight targets an unmapped address
    logic   r_fault;
    logic   w_oor_next;
    logic   w_set_fault;

    logic [32:0] w_i_off;
    logic [32:0] w_d_off;
    logic        w_i_oor;
    logic        w_d_oor;
    logic        w_i_pend;
    logic        w_d_pend;
    logic        w_grant_d;
    logic        w_grant_i;

    assign w_i_off  = {1'b0, i_address} - {1'b0, BASE};
    assign w_d_off  = {1'b0, d_address} - {1'b0, BASE};
    assign w_i_oor  = (w_i_off >= c_SPAN);
    assign w_d_oor  = (w_d_off >= c_SPAN);
    assign w_i_pend = i_read;
    assign w_d_pend = d_read | d_write;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic r_prio_d;        // 1: data port wins the next tie

    assign w_grant_d = w_d_pend && (!w_i_pend || r_prio_d);

    // Priority flips to the other port after every grant made in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio_d <= 1'b1;
        end else if (r_state == IDLE) begin
            if (w_grant_d) begin
                r_prio_d <= 1'b0;
            end else if (w_grant_i) begin
                r_prio_d <= 1'b1;
            end
        end
    end
`else
    assign w_grant_d = w_d_pend;
`endif

    assign w_grant_i = w_i_pend && !w_grant_d;

    assign ram_writedata = d_writedata;
    assign fault         = r_fault & ~reset;

    // State register, in-flight range flag and sticky fault
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rd_oor <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rd_oor <= w_oor_next;
            r_fault  <= r_fault | w_set_fault;
        end
    end

    // Grant decode, RAM strobes and port handshakes
    always_comb begin
        w_state_next   = IDLE;
        w_oor_next     = 1'b0;
        w_set_fault    = 1'b0;
        i_waitrequest  = 1'b1;
        d_waitrequest  = 1'b1;
        i_readdata     = 32'h0;
        d_readdata     = 32'h0;
        ram_read       = 1'b0;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_byteenable = 4'hF;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        ram_address = w_d_off[ADDR_W+1:2];
                        w_set_fault = w_d_oor;
                        if (d_write) begin
                            // write wins over a simultaneous read
                            ram_write      = !w_d_oor;
                            ram_byteenable = d_byteenable;
                            d_waitrequest  = 1'b0;
                        end else begin
                            ram_read     = !w_d_oor;
                            w_oor_next   = w_d_oor;
                            w_state_next = RD_D;
                        end
                    end else if (w_grant_i) begin
                        ram_address  = w_i_off[ADDR_W+1:2];
                        w_set_fault  = w_i_oor;
                        ram_read     = !w_i_oor;
                        w_oor_next   = w_i_oor;
                        w_state_next = RD_I;
                    end
                end
                RD_I: begin
                    // a dropped request gets no data, state still returns
                    if (i_read) begin
                        i_waitrequest = 1'b0;
                        i_readdata    = r_rd_oor ? 32'h0 : ram_readdata;
                    end
                end
                RD_D: begin
                    if (d_read) begin
                        d_waitrequest = 1'b0;
                        d_readdata    = r_rd_oor ? 32'h0 : ram_readdata;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed vector table,
//            hand-written multi-cycle sequences and a randomized phase
//            checked against a transaction-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int          ADDR_W = 12;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          WORDS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       i_address;
    logic              i_read;
    logic              i_waitrequest;
    logic [31:0]       i_readdata;
    logic [31:0]       d_address;
    logic              d_read;
    logic              d_write;
    logic [3:0]        d_byteenable;
    logic [31:0]       d_writedata;
    logic              d_waitrequest;
    logic [31:0]       d_readdata;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_read;
    logic              ram_write;
    logic [3:0]        ram_byteenable;
    logic [31:0]       ram_writedata;
    logic [31:0]       ram_readdata;
    logic              fault;

    mem_arbiter #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_byteenable(d_byteenable), .d_writedata(d_writedata),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
        .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
        .ram_readdata(ram_readdata), .fault(fault)
    );

    always #5 clk = ~clk;

    // Environment RAM: registered read, byte-lane writes
    logic [31:0] ram [WORDS];
    always @(posedge clk) begin
        if (ram_read) ram_readdata <= ram[ram_address];
        if (ram_write) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteenable[b]) ram[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
    end

    function automatic logic [31:0] init_word(int k);
        if (k == 1) return 32'h1234_5678;
        if (k == 2) return 32'h0;
        return 32'h5A5A_0000 ^ (k * 32'h0101_0101);
    endfunction

    typedef struct packed {
        logic              rst;
        logic              ir;
        logic [31:0]       ia;
        logic              dr;
        logic              dw;
        logic [31:0]       da;
        logic [3:0]        be;
        logic [31:0]       wd;
        logic              e_iw;
        logic              e_dw;
        logic              e_rr;
        logic              e_rw;
        logic [ADDR_W-1:0] e_ra;
        logic [3:0]        e_be;
        logic              e_flt;
        logic [31:0]       e_ird;
        logic [31:0]       e_drd;
    } vec_t;

    function automatic vec_t V(logic rst, logic ir, logic [31:0] ia, logic dr, logic dw,
                               logic [31:0] da, logic [3:0] be, logic [31:0] wd,
                               logic iw, logic dwq, logic rr, logic rw, logic [ADDR_W-1:0] ra,
                               logic [3:0] rbe, logic flt, logic [31:0] ird, logic [31:0] drd);
        vec_t v;
        v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.be = be; v.wd = wd;
        v.e_iw = iw; v.e_dw = dwq; v.e_rr = rr; v.e_rw = rw; v.e_ra = ra; v.e_be = rbe;
        v.e_flt = flt; v.e_ird = ird; v.e_drd = drd;
        return v;
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, compare settled outputs at the falling edge
    task automatic run(vec_t v, string tag);
        reset = v.rst; i_read = v.ir; i_address = v.ia; d_read = v.dr; d_write = v.dw;
        d_address = v.da; d_byteenable = v.be; d_writedata = v.wd;
        @(negedge clk);
        chk({tag, ".i_waitrequest"}, i_waitrequest, v.e_iw);
        chk({tag, ".d_waitrequest"}, d_waitrequest, v.e_dw);
        chk({tag, ".i_readdata"}, i_readdata, v.e_ird);
        chk({tag, ".d_readdata"}, d_readdata, v.e_drd);
        chk({tag, ".ram_read"}, ram_read, v.e_rr);
        chk({tag, ".ram_write"}, ram_write, v.e_rw);
        chk({tag, ".fault"}, fault, v.e_flt);
        if (v.e_rr || v.e_rw) begin
            chk({tag, ".ram_address"}, ram_address, v.e_ra);
            chk({tag, ".ram_byteenable"}, ram_byteenable, v.e_be);
        end
        if (v.e_rw) chk({tag, ".ram_writedata"}, ram_writedata, v.wd);
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] mmem [WORDS];
    bit m_busy;       // a read was granted last cycle and completes now
    bit m_port_d;     // which port owns that read
    int m_word;
    bit m_oor;
    bit m_fault;
    bit m_prio_d;

    function automatic bit out_of_range(logic [31:0] a);
        return (longint'(a) < longint'(BASE)) ||
               (longint'(a) >= longint'(BASE) + 4 * longint'(WORDS));
    endfunction

    task automatic model_step(inout vec_t v);
        bit d_wins;
        bit oor;
        int w;
        v.e_iw = 1; v.e_dw = 1; v.e_rr = 0; v.e_rw = 0; v.e_ra = '0; v.e_be = 4'hF;
        v.e_ird = 0; v.e_drd = 0; v.e_flt = m_fault && !v.rst;
        if (v.rst) begin
            m_busy = 0; m_fault = 0; m_prio_d = 1;
        end else if (m_busy) begin
            if (!m_port_d && v.ir) begin
                v.e_iw = 0; v.e_ird = m_oor ? 32'h0 : mmem[m_word];
            end
            if (m_port_d && v.dr) begin
                v.e_dw = 0; v.e_drd = m_oor ? 32'h0 : mmem[m_word];
            end
            m_busy = 0;
        end else if (v.ir || v.dr || v.dw) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            d_wins = (v.dr || v.dw) && (!v.ir || m_prio_d);
`else
            d_wins = (v.dr || v.dw);
`endif
            oor = out_of_range(d_wins ? v.da : v.ia);
            w   = int'(((d_wins ? v.da : v.ia) - BASE) >> 2) % WORDS;
            v.e_ra = w[ADDR_W-1:0];
            m_fault = m_fault || oor;
            m_prio_d = !d_wins;
            if (d_wins && v.dw) begin
                v.e_dw = 0; v.e_rw = !oor; v.e_be = v.be;
                if (!oor)
                    for (int b = 0; b < 4; b++)
                        if (v.be[b]) mmem[w][8*b +: 8] = v.wd[8*b +: 8];
            end else begin
                v.e_rr = !oor;
                m_busy = 1; m_port_d = d_wins; m_word = w; m_oor = oor;
            end
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 7) == 0)
            return ($urandom_range(0, 1) == 0) ? 32'(WORDS * 4 + $urandom_range(0, 63)) : 32'hFFFF_FFF0;
        return BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
    endfunction

    vec_t tbl[$];

    initial begin
        reset = 1; i_read = 0; i_address = 0; d_read = 0; d_write = 0;
        d_address = 0; d_byteenable = 0; d_writedata = 0;
        for (int k = 0; k < WORDS; k++) begin
            ram[k] = init_word(k);
            mmem[k] = init_word(k);
        end

        // ------------- directed vector table -------------
        tbl.push_back(V(1,0,0,0,0,0,0,0,                         1,1,0,0,0,4'hF,0,0,0));
        tbl.push_back(V(1,1,4,1,0,8,0,0,                         1,1,0,0,0,4'hF,0,0,0));
        tbl.push_back(V(0,0,0,0,1,8,4'b0011,32'hAABBCCDD,        1,0,0,1,2,4'b0011,0,0,0));
        tbl.push_back(V(0,1,4,0,0,0,0,0,                         1,1,1,0,1,4'hF,0,0,0));
        tbl.push_back(V(0,1,4,0,0,0,0,0,                         0,1,0,0,0,4'hF,0,32'h12345678,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,                         1,1,0,0,0,4'hF,0,0,0));
        tbl.push_back(V(0,0,0,1,0,8,0,0,                         1,1,1,0,2,4'hF,0,0,0));
        tbl.push_back(V(0,0,0,1,0,8,0,0,                         1,0,0,0,0,4'hF,0,0,32'h0000CCDD));
        tbl.push_back(V(0,0,0,1,1,32'hC,4'hF,32'h11112222,       1,0,0,1,3,4'hF,0,0,0));
        tbl.push_back(V(0,0,0,1,0,32'hC,0,0,                     1,1,1,0,3,4'hF,0,0,0));
        tbl.push_back(V(0,0,0,1,0,32'hC,0,0,                     1,0,0,0,0,4'hF,0,0,32'h11112222));
        tbl.push_back(V(0,1,7,0,0,0,0,0,                         1,1,1,0,1,4'hF,0,0,0));
        tbl.push_back(V(0,1,7,0,0,0,0,0,                         0,1,0,0,0,4'hF,0,32'h12345678,0));
        tbl.push_back(V(0,0,0,1,0,4,0,0,                         1,1,1,0,1,4'hF,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,                         1,1,0,0,0,4'hF,0,0,0));
        tbl.push_back(V(0,0,0,1,0,32'h4000,0,0,                  1,1,0,0,0,4'hF,0,0,0));
        tbl.push_back(V(0,0,0,1,0,32'h4000,0,0,                  1,0,0,0,0,4'hF,1,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,                         1,1,0,0,0,4'hF,1,0,0));
        tbl.push_back(V(0,0,0,0,1,32'hFFFFFFFC,4'hF,32'hDEADBEEF,1,0,0,0,0,4'hF,1,0,0));
        tbl.push_back(V(1,0,0,0,0,0,0,0,                         1,1,0,0,0,4'hF,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,                         1,1,0,0,0,4'hF,0,0,0));
        foreach (tbl[n]) run(tbl[n], $sformatf("vec%0d", n));

        // ------------- reset while a data read is in flight -------------
        run(V(0,0,0,1,0,32'h4000,0,0,   1,1,0,0,0,4'hF,0,0,0), "rst_rd.oor0");
        run(V(0,0,0,1,0,32'h4000,0,0,   1,0,0,0,0,4'hF,1,0,0), "rst_rd.oor1");
        run(V(0,0,0,1,0,32'h10,0,0,     1,1,1,0,4,4'hF,1,0,0), "rst_rd.grant");
        run(V(1,0,0,1,0,32'h10,0,0,     1,1,0,0,0,4'hF,0,0,0), "rst_rd.reset");
        run(V(0,0,0,0,0,0,0,0,          1,1,0,0,0,4'hF,0,0,0), "rst_rd.idle");
        run(V(0,0,0,1,0,32'h10,0,0,     1,1,1,0,4,4'hF,0,0,0), "rst_rd.regrant");
        run(V(0,0,0,1,0,32'h10,0,0,     1,0,0,0,0,4'hF,0,0,init_word(4)), "rst_rd.done");

        // ------------- contention, both reads held for 4 cycles -------------
        run(V(1,0,0,0,0,0,0,0,          1,1,0,0,0,4'hF,0,0,0), "cont.reset");
        run(V(0,1,4,1,0,32'h10,0,0,     1,1,1,0,4,4'hF,0,0,0), "cont.c0");
        run(V(0,1,4,1,0,32'h10,0,0,     1,0,0,0,0,4'hF,0,0,init_word(4)), "cont.c1");
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        run(V(0,1,4,1,0,32'h10,0,0,     1,1,1,0,1,4'hF,0,0,0), "cont.c2");
        run(V(0,1,4,1,0,32'h10,0,0,     0,1,0,0,0,4'hF,0,32'h12345678,0), "cont.c3");
`else
        run(V(0,1,4,1,0,32'h10,0,0,     1,1,1,0,4,4'hF,0,0,0), "cont.c2");
        run(V(0,1,4,1,0,32'h10,0,0,     1,0,0,0,0,4'hF,0,0,init_word(4)), "cont.c3");
`endif

        // ------------- randomized phase against the reference model -------------
        for (int k = 0; k < WORDS; k++) begin
            ram[k] = init_word(k);
            mmem[k] = init_word(k);
        end
        m_busy = 0; m_fault = 0; m_prio_d = 1;
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v = '0;
            v.rst = (n == 0) || ($urandom_range(0, 49) == 0);
            v.ir  = ($urandom_range(0, 2) != 0);
            v.ia  = rnd_addr();
            v.dr  = ($urandom_range(0, 1) != 0);
            v.dw  = ($urandom_range(0, 3) == 0);
            v.da  = rnd_addr();
            v.be  = 4'($urandom_range(0, 15));
            v.wd  = $urandom;
            model_step(v);
            run(v, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
